// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared types and constants for the 3-byte remote command receiver.
//   rx_state_t    : receive framing states (WAIT_CMD -> WAIT_HI -> WAIT_LO)
//   CMD_BYTES     : bytes per command frame (opcode, data high, data low)
//   CMD_W         : width of an assembled frame
//   TO_CYCLES_DEF : default inter-byte timeout (50 ms at 50 MHz)
//   BAUD_DIV_DEF  : default clk cycles per UART bit (115200 baud at 50 MHz)
// -----------------------------------------------------------------------------
package cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_CMD,
    WAIT_HI,
    WAIT_LO
  } rx_state_t;

  localparam int          CMD_BYTES     = 3;
  localparam int          CMD_W         = 8 * CMD_BYTES;
  localparam logic [21:0] TO_CYCLES_DEF = 22'd2_500_000;
  localparam int          BAUD_DIV_DEF  = 434;

endpackage

// File: rtl/UART.sv
// -----------------------------------------------------------------------------
// UART
// 8N1 transceiver, LSB-first on the wire.
//   clk, rst_n  : clock, asynchronous active-low reset
//   RX          : serial input (synchronised internally)
//   TX          : serial output, idles high
//   rx_rdy      : sticky flag, a received byte is in rx_data
//   clr_rx_rdy  : clears rx_rdy on the next edge
//   rx_data     : last received byte
//   trmt        : start transmitting tx_data (ignored while busy)
//   tx_data     : byte to transmit, sampled when trmt is accepted
//   tx_done     : one-cycle pulse at the end of the stop bit
// Parameter BAUD_DIV: clk cycles per bit.
// -----------------------------------------------------------------------------
module UART #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------- receiver ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_busy;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sr;
  logic          w_rx_tick;

  // Bit 0 (start) is sampled half a bit after the falling edge, so every
  // later sample lands mid-bit.
  assign w_rx_tick = (r_rx_cnt == ((r_rx_bit == 4'd0) ? HALF_LAST : BIT_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bit  <= 4'd0;
      r_rx_sr   <= 8'h00;
      rx_data   <= 8'h00;
      rx_rdy    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic, so every
      // register sees the pre-edge value of every other register.
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;  // a byte completing below overrides this
      if (!r_rx_busy) begin
        if (!r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= '0;
          r_rx_bit  <= 4'd0;
        end
      end else if (!w_rx_tick) begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end else begin
        r_rx_cnt <= '0;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_busy <= 1'b0;  // glitch, not a real start bit
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          rx_data   <= r_rx_sr;
          rx_rdy    <= 1'b1;
        end else begin
          r_rx_sr <= {r_rx_s2, r_rx_sr[7:1]};
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic [8:0]    r_tx_sr;
  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sr   <= '1;
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= 4'd0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !r_tx_busy) begin
        r_tx_sr   <= {tx_data, 1'b0};
        r_tx_busy <= 1'b1;
        r_tx_cnt  <= '0;
        r_tx_bit  <= 4'd0;
      end else if (r_tx_busy) begin
        if (r_tx_cnt != BIT_LAST) begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end else begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 4'd9) begin
            r_tx_busy <= 1'b0;
            tx_done   <= 1'b1;
          end else begin
            // Shifting ones in leaves the stop bit (and idle) at bit 0.
            r_tx_sr  <= {1'b1, r_tx_sr[8:1]};
            r_tx_bit <= r_tx_bit + 4'd1;
          end
        end
      end
    end
  end

  assign TX = r_tx_sr[0];

endmodule

// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
// Device-side receiver for the 3-byte remote command protocol
// (cmd, data[15:8], data[7:0]) and return path for an 8-bit response.
//   clk, rst_n   : clock, asynchronous active-low reset
//   RX, TX       : serial link to the remote command transmitter
//   cmd, data    : opcode / data of the last complete command
//   cmd_rdy      : sticky, complete command available
//   clr_cmd_rdy  : processor acknowledge, clears cmd_rdy
//   resp         : response byte
//   send_resp    : single-cycle request to transmit resp
//   resp_sent    : one-cycle pulse when the response has been sent
// Build option CMD_TIMEOUT_EN: drop a partial frame after TO_CYCLES idle
// cycles between bytes (the TO_CYCLES parameter exists only in that build).
// -----------------------------------------------------------------------------
module uart_cmd_wrapper
  import cmd_pkg::*;
#(
`ifdef CMD_TIMEOUT_EN
  parameter logic [21:0] TO_CYCLES = TO_CYCLES_DEF,
`endif
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  rx_state_t        r_state, w_next_state;
  logic             w_rx_rdy, w_clr_rx_rdy, w_tx_done;
  logic [7:0]       w_rx_data;
  logic             w_cap_cmd, w_cap_hi, w_complete, w_timeout;
  logic [7:0]       r_cmd_shadow, r_hi_shadow, r_resp;
  logic [CMD_W-1:0] w_frame;
  logic             r_trmt, r_tx_busy, w_resp_accept;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (w_rx_rdy),
    .clr_rx_rdy (w_clr_rx_rdy),
    .rx_data    (w_rx_data),
    .trmt       (r_trmt),
    .tx_data    (r_resp),
    .tx_done    (w_tx_done)
  );

  // ---------------- receive framing FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WAIT_CMD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_clr_rx_rdy = 1'b0;
    w_cap_cmd    = 1'b0;
    w_cap_hi     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      WAIT_CMD: if (w_rx_rdy) begin
        w_clr_rx_rdy = 1'b1;
        w_cap_cmd    = 1'b1;
        w_next_state = WAIT_HI;
      end
      WAIT_HI: if (w_rx_rdy) begin
        w_clr_rx_rdy = 1'b1;
        w_cap_hi     = 1'b1;
        w_next_state = WAIT_LO;
      end else if (w_timeout) begin
        w_next_state = WAIT_CMD;
      end
      WAIT_LO: if (w_rx_rdy) begin
        w_clr_rx_rdy = 1'b1;
        w_complete   = 1'b1;
        w_next_state = WAIT_CMD;
      end else if (w_timeout) begin
        w_next_state = WAIT_CMD;
      end
      default: w_next_state = WAIT_CMD;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  // Idle counter between bytes of a frame; restarts on every captured byte.
  logic [21:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_to_cnt <= 22'd0;
    else if (r_state == WAIT_CMD || w_rx_rdy || w_timeout) r_to_cnt <= 22'd0;
    else                                                 r_to_cnt <= r_to_cnt + 22'd1;
  end

  assign w_timeout = (r_to_cnt == TO_CYCLES - 22'd1);
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------- command assembly ----------------
  // The third byte goes straight from the UART into the outputs, so cmd and
  // data only ever change as a complete, consistent triple.
  assign w_frame = {r_cmd_shadow, r_hi_shadow, w_rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_shadow <= 8'h00;
      r_hi_shadow  <= 8'h00;
      cmd          <= 8'h00;
      data         <= 16'h0000;
      cmd_rdy      <= 1'b0;
    end else begin
      if (w_cap_cmd) r_cmd_shadow <= w_rx_data;
      if (w_cap_hi)  r_hi_shadow  <= w_rx_data;
      if (w_complete) begin
        cmd  <= w_frame[23:16];
        data <= w_frame[15:0];
      end
      // Completion beats acknowledge; a new first byte retires a stale command.
      if (w_complete)                    cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || w_cap_cmd) cmd_rdy <= 1'b0;
    end
  end

  // ---------------- response path ----------------
  // Requests during a transmission are dropped, so r_resp stays stable.
  assign w_resp_accept = send_resp && !r_tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp    <= 8'h00;
      r_trmt    <= 1'b0;
      r_tx_busy <= 1'b0;
    end else begin
      r_trmt <= w_resp_accept;
      if (w_resp_accept) r_resp <= resp;
      if (w_resp_accept)  r_tx_busy <= 1'b1;
      else if (w_tx_done) r_tx_busy <= 1'b0;
    end
  end

  assign resp_sent = w_tx_done;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
// Directed bench for uart_cmd_wrapper. Expected commands and responses are
// queued when stimulus is driven and popped when the DUT produces them.
// Honours CMD_TIMEOUT_EN for the timeout scenario.
// -----------------------------------------------------------------------------
module tb_uart_cmd_wrapper;

  localparam int          BAUD = 16;
  localparam logic [21:0] TO   = 22'd1000;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } exp_cmd_t;

  logic        clk, rst_n, RX, TX;
  logic [7:0]  cmd, resp;
  logic [15:0] data;
  logic        cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;

  exp_cmd_t    cmd_q[$];
  logic [7:0]  resp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          resp_sent_cycles = 0;
  bit          saw_be01 = 0;
  logic        prev_cmd_rdy = 1'b0;
  logic        prev_rx_rdy  = 1'b0;
  exp_cmd_t    mon_e;

  uart_cmd_wrapper #(
`ifdef CMD_TIMEOUT_EN
    .TO_CYCLES (TO),
`endif
    .BAUD_DIV  (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); RX = 1'b0;
    repeat (BAUD - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); RX = b[i];
      repeat (BAUD - 1) @(negedge clk);
    end
    @(negedge clk); RX = 1'b1;
    repeat (BAUD - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic ack_cmd();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
  endtask

  // Receive one byte from TX and compare it with the response scoreboard.
  task automatic rx_resp();
    logic [7:0] b;
    logic [7:0] e;
    b = 8'h00;
    for (int i = 0; i < 2000 && TX !== 1'b0; i++) @(negedge clk);
    check("tx_start_bit", TX, 1'b0);
    repeat (BAUD / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      b[i] = TX;
    end
    repeat (BAUD) @(negedge clk);
    check("tx_stop_bit", TX, 1'b1);
    check("resp_sb_nonempty", resp_q.size() != 0, 1'b1);
    if (resp_q.size() != 0) begin
      e = resp_q.pop_front();
      check("resp_byte", b, e);
    end
  endtask

  // Output monitor: pops the command scoreboard on each cmd_rdy rise.
  always @(negedge clk) begin
    if (rst_n && cmd_rdy === 1'b1 && prev_cmd_rdy === 1'b0) begin
      check("cmd_rdy_latency", prev_rx_rdy, 1'b1);
      check("cmd_sb_nonempty", cmd_q.size() != 0, 1'b1);
      if (cmd_q.size() != 0) begin
        mon_e = cmd_q.pop_front();
        check("sb_cmd", cmd, mon_e.c);
        check("sb_data", data, mon_e.d);
      end
    end
    if (data === 16'hBE01) saw_be01 = 1'b1;
    if (resp_sent === 1'b1) resp_sent_cycles++;
    prev_cmd_rdy = cmd_rdy;
    prev_rx_rdy  = dut.w_rx_rdy;
  end

  initial begin
    logic [7:0]  exp_c;
    logic [15:0] exp_d;
    logic        exp_rdy;

    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_cmd", cmd, 8'h00);
    check("rst_data", data, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 1'b0);
    check("rst_resp_sent", resp_sent, 1'b0);
    check("rst_tx_idle", TX, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single command, sticky cmd_rdy, acknowledge
    cmd_q.push_back('{8'h2A, 16'h1234});
    send_frame(8'h2A, 16'h1234);
    repeat (20) @(negedge clk);
    check("t1_cmd_rdy_sticky", cmd_rdy, 1'b1);
    check("t1_cmd", cmd, 8'h2A);
    check("t1_data", data, 16'h1234);
    ack_cmd();
    check("t1_cmd_rdy_cleared", cmd_rdy, 1'b0);
    check("t1_cmd_held", cmd, 8'h2A);

    // 2: back-to-back commands, no acknowledge between them
    cmd_q.push_back('{8'h05, 16'hBEEF});
    send_frame(8'h05, 16'hBEEF);
    cmd_q.push_back('{8'h06, 16'h0001});
    send_byte(8'h06);
    check("t2_stale_cleared", cmd_rdy, 1'b0);
    check("t2_cmd_not_partial", cmd, 8'h05);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (20) @(negedge clk);
    check("t2_cmd_rdy", cmd_rdy, 1'b1);
    check("t2_cmd", cmd, 8'h06);
    check("t2_data", data, 16'h0001);
    check("t2_no_mixed_data", saw_be01, 1'b0);
    ack_cmd();

    // 3: response with an ignored second request, while a command arrives
    resp_sent_cycles = 0;
    resp_q.push_back(8'hA5);
    cmd_q.push_back('{8'h3C, 16'h4D5E});
    @(negedge clk); resp = 8'hA5; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; resp = 8'h00;
    fork
      rx_resp();
      send_frame(8'h3C, 16'h4D5E);
      begin
        repeat (60) @(negedge clk);
        resp = 8'h5A; send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    check("t3_resp_sent_cycles", resp_sent_cycles, 1);
    check("t3_tx_idle", TX, 1'b1);
    check("t3_cmd", cmd, 8'h3C);
    check("t3_data", data, 16'h4D5E);
    ack_cmd();

    // 4: reset mid-frame, then a clean frame
    send_byte(8'h99);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_rst_cmd", cmd, 8'h00);
    check("t4_rst_data", data, 16'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    cmd_q.push_back('{8'h11, 16'h2233});
    send_frame(8'h11, 16'h2233);
    repeat (20) @(negedge clk);
    check("t4_cmd", cmd, 8'h11);
    check("t4_data", data, 16'h2233);
    ack_cmd();

    // 6: acknowledge in the completion cycle
    cmd_q.push_back('{8'h42, 16'hBEEF});
    send_byte(8'h42);
    send_byte(8'hBE);
    fork
      send_byte(8'hEF);
      begin
        for (int i = 0; i < 400 && dut.w_rx_rdy !== 1'b1; i++) @(negedge clk);
        check("t6_third_byte_seen", dut.w_rx_rdy, 1'b1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("t6_cmd_rdy_wins", cmd_rdy, 1'b1);
    check("t6_cmd", cmd, 8'h42);
    check("t6_data", data, 16'hBEEF);
    ack_cmd();

    // 5: lost-byte resynchronisation
`ifdef CMD_TIMEOUT_EN
    cmd_q.push_back('{8'h01, 16'hABCD});
    exp_c = 8'h01; exp_d = 16'hABCD; exp_rdy = 1'b1;
`else
    cmd_q.push_back('{8'h77, 16'h01AB});
    exp_c = 8'h77; exp_d = 16'h01AB; exp_rdy = 1'b0;
`endif
    send_byte(8'h77);
    repeat (1200) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (20) @(negedge clk);
    check("t5_cmd", cmd, exp_c);
    check("t5_data", data, exp_d);
    check("t5_cmd_rdy", cmd_rdy, exp_rdy);

    // Every queued expectation must have been consumed
    check("cmd_sb_drained", cmd_q.size(), 0);
    check("resp_sb_drained", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
